// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline control for the 5-stage RV32 core.
//
// Merges four request sources into per-stage stall/flush controls and the
// PC redirect:
//   decode load-use (stallreq_id_i), execute multi-cycle busy (stallreq_ex_i),
//   execute jump/branch (jump_req_i/jump_addr_i), bus hold (hold_req_i).
// Priority: jump > execute busy > load-use > bus hold.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   stallreq_id_i       load-use hazard (combinational from decode)
//   stallreq_ex_i       execute unit busy with a multi-cycle op
//   jump_req_i          taken branch/jump, target on jump_addr_i
//   hold_req_i          bus master asks for the core to be held
//   stall_o[STALL_W]    hold enables: bit0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb
//   flush_o             squash if_id and id_exe
//   jump_flag_o         PC load strobe, jump_addr_o is the load value
//   hold_ack_o          core frozen, bus granted
//   mc_err_o            sticky: execute stayed busy MC_TIMEOUT cycles
//   state_o             debug view of the control FSM (0 RUN, 1 MC_WAIT, 2 FLUSH, 3 HOLD)
//
// Optional build macro PIPE_CTRL_PERF_EN adds perf_stall_cnt_o,
// perf_flush_cnt_o and perf_hold_cnt_o (32-bit wrapping event counters).

module pipe_ctrl #(
    parameter int STALL_W    = 5,
    parameter int FLUSH_CYC  = 2,
    parameter int MC_TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               jump_req_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               hold_req_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               jump_flag_o,
    output logic [31:0]        jump_addr_o,
    output logic               hold_ack_o,
    output logic               mc_err_o,
    output logic [1:0]         state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt_o,
    output logic [31:0]        perf_flush_cnt_o,
    output logic [31:0]        perf_hold_cnt_o
`endif
);

    localparam int FW = 3;
    localparam int BW = $clog2(MC_TIMEOUT) + 1;

    localparam logic [STALL_W-1:0] STALL_EX  = STALL_W'(7);
    localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(3);
    localparam logic [STALL_W-1:0] STALL_ALL = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // The jump cycle itself is the first flush cycle, so a one-cycle flush
    // never needs the FLUSH state at all.
    localparam state_t JUMP_DEST = (FLUSH_CYC > 1) ? FLUSH : RUN;

    state_t                state;
    logic [FW-1:0]         flush_cnt;
    logic [BW-1:0]         busy_cnt;
    logic [BW-1:0]         busy_inc;
    logic                  mc_err_q;
    logic [31:0]           addr_q;
    logic                  jump_take;
    logic                  busy_active;
    logic [STALL_W-1:0]    stall_c;

    // The pipeline is frozen in HOLD, so a jump seen there is stale and ignored.
    // Gating with rst_n_i makes every output drop the moment reset asserts.
    assign jump_take = rst_n_i && jump_req_i && (state != HOLD);

    // Execute busy is only honoured in RUN/MC_WAIT and only when no jump wins.
    assign busy_active = (state == RUN || state == MC_WAIT) && !jump_take && stallreq_ex_i;

    assign busy_inc = (busy_cnt >= BW'(MC_TIMEOUT)) ? busy_cnt : busy_cnt + BW'(1);

    // Per-stage hold enables, combinational from state and requests.
    always_comb begin
        stall_c = '0;
        unique case (state)
            RUN, MC_WAIT: begin
                if (jump_take)
                    stall_c = '0;
                else if (stallreq_ex_i)
                    stall_c = STALL_EX;
                else if (stallreq_id_i)
                    stall_c = STALL_ID;
            end
            FLUSH:   stall_c = '0;
            HOLD:    stall_c = hold_req_i ? STALL_ALL : '0;
            default: stall_c = '0;
        endcase
    end

    // Bus hold handshake: hold_req_i is a level request held by the bus master
    // until it is done; hold_ack_o rises on the first HOLD cycle and stays high
    // while the core is frozen; dropping hold_req_i releases the pipeline in the
    // same cycle and hold_ack_o falls on the next. Requests that arrive while a
    // flush or multi-cycle wait is in progress wait for RUN before being granted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= RUN;
            flush_cnt <= '0;
            busy_cnt  <= '0;
            mc_err_q  <= 1'b0;
            addr_q    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (jump_take)
                        state <= JUMP_DEST;
                    else if (stallreq_ex_i)
                        state <= MC_WAIT;
                    else if (!stallreq_id_i && hold_req_i)
                        state <= HOLD;
                end
                MC_WAIT: begin
                    if (jump_take)
                        state <= JUMP_DEST;
                    else if (!stallreq_ex_i)
                        state <= RUN;
                end
                FLUSH: begin
                    // Counter holds the flush cycles still owed including this one.
                    if (jump_take)
                        state <= JUMP_DEST;
                    else if (flush_cnt <= FW'(1))
                        state <= RUN;
                end
                HOLD: begin
                    if (!hold_req_i)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase

            if (jump_take)
                flush_cnt <= FW'(FLUSH_CYC - 1);
            else if (state == FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);

            if (busy_active) begin
                busy_cnt <= busy_inc;
                if (busy_inc == BW'(MC_TIMEOUT))
                    mc_err_q <= 1'b1;
            end else begin
                busy_cnt <= '0;
            end

            if (jump_take)
                addr_q <= jump_addr_i;
        end
    end

    assign stall_o     = rst_n_i ? stall_c : '0;
    assign flush_o     = jump_take || (state == FLUSH);
    assign jump_flag_o = jump_take;
    // Live target on the strobe cycle, otherwise the last redirect taken.
    assign jump_addr_o = jump_take ? jump_addr_i : addr_q;
    assign hold_ack_o  = (state == HOLD);
    assign mc_err_o    = mc_err_q;
    assign state_o     = state;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
            perf_hold_cnt_o  <= '0;
        end else begin
            if (|stall_c)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (jump_take)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            if (state == HOLD)
                perf_hold_cnt_o <= perf_hold_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. A cycle-level behavioural model predicts
// the outputs for each driven cycle into exp_q; the sample point pops and compares.

module tb_pipe_ctrl;

    localparam int STALL_W    = 5;
    localparam int FLUSH_CYC  = 2;
    localparam int MC_TIMEOUT = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               stallreq_id;
    logic               stallreq_ex;
    logic               jump_req;
    logic [31:0]        jump_addr;
    logic               hold_req;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               jump_flag;
    logic [31:0]        jump_addr_out;
    logic               hold_ack;
    logic               mc_err;
    logic [1:0]         state_dbg;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_flush_cnt;
    logic [31:0]        perf_hold_cnt;
`endif

    pipe_ctrl #(
        .STALL_W    (STALL_W),
        .FLUSH_CYC  (FLUSH_CYC),
        .MC_TIMEOUT (MC_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stallreq_id_i (stallreq_id),
        .stallreq_ex_i (stallreq_ex),
        .jump_req_i    (jump_req),
        .jump_addr_i   (jump_addr),
        .hold_req_i    (hold_req),
        .stall_o       (stall),
        .flush_o       (flush),
        .jump_flag_o   (jump_flag),
        .jump_addr_o   (jump_addr_out),
        .hold_ack_o    (hold_ack),
        .mc_err_o      (mc_err),
        .state_o       (state_dbg)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt),
        .perf_hold_cnt_o  (perf_hold_cnt)
`endif
    );

    // scoreboard: {stall[4:0], flush, jump_flag, jump_addr[31:0], hold_ack, mc_err}
    logic [40:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int flush_seen = 0;

    // behavioural model: mode 0 run, 1 execute wait, 2 flushing, 3 held
    int          m_mode;
    int          m_flush_left;
    int          m_busy;
    logic        m_err;
    logic [31:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_flush_left = 0;
        m_busy       = 0;
        m_err        = 1'b0;
        m_addr       = 32'h0;
    endtask

    // Called at posedge+1: drives one cycle, predicts, samples at posedge+3.
    task automatic drive(input logic id, input logic ex, input logic jmp,
                         input logic [31:0] addr, input logic hold);
        logic [4:0]  e_stall;
        logic        e_flush;
        logic        e_jf;
        logic [31:0] e_addr;
        logic        e_ack;
        logic        e_err;
        logic [40:0] a;
        int          next_mode;
        logic        count_busy;

        stallreq_id = id;
        stallreq_ex = ex;
        jump_req    = jmp;
        jump_addr   = addr;
        hold_req    = hold;

        e_stall    = 5'b0;
        e_flush    = 1'b0;
        e_jf       = 1'b0;
        e_addr     = m_addr;
        e_ack      = (m_mode == 3);
        e_err      = m_err;
        next_mode  = m_mode;
        count_busy = 1'b0;

        if (jmp && m_mode != 3) begin
            e_jf         = 1'b1;
            e_flush      = 1'b1;
            e_addr       = addr;
            m_addr       = addr;
            m_flush_left = FLUSH_CYC - 1;
            next_mode    = (m_flush_left > 0) ? 2 : 0;
        end else begin
            case (m_mode)
                0: begin
                    if (ex) begin
                        e_stall    = 5'b00111;
                        count_busy = 1'b1;
                        next_mode  = 1;
                    end else if (id) begin
                        e_stall = 5'b00011;
                    end else if (hold) begin
                        next_mode = 3;
                    end
                end
                1: begin
                    if (ex) begin
                        e_stall    = 5'b00111;
                        count_busy = 1'b1;
                    end else begin
                        next_mode = 0;
                        if (id) e_stall = 5'b00011;
                    end
                end
                2: begin
                    e_flush = 1'b1;
                    m_flush_left--;
                    if (m_flush_left == 0) next_mode = 0;
                end
                default: begin
                    if (hold) e_stall = 5'b11111;
                    else      next_mode = 0;
                end
            endcase
        end

        exp_q.push_back({e_stall, e_flush, e_jf, e_addr, e_ack, e_err});

        #2;
        a = exp_q.pop_front();
        check("stall",     32'(stall),     32'(a[40:36]));
        check("flush",     32'(flush),     32'(a[35]));
        check("jump_flag", 32'(jump_flag), 32'(a[34]));
        check("jump_addr", jump_addr_out,  a[33:2]);
        check("hold_ack",  32'(hold_ack),  32'(a[1]));
        check("mc_err",    32'(mc_err),    32'(a[0]));
        if (flush) flush_seen++;

        if (count_busy) begin
            if (m_busy < MC_TIMEOUT) m_busy++;
            if (m_busy == MC_TIMEOUT) m_err = 1'b1;
        end else begin
            m_busy = 0;
        end
        m_mode = next_mode;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},     32'(stall),     32'h0);
        check({tag, "_flush"},     32'(flush),     32'h0);
        check({tag, "_jump_flag"}, 32'(jump_flag), 32'h0);
        check({tag, "_jump_addr"}, jump_addr_out,  32'h0);
        check({tag, "_hold_ack"},  32'(hold_ack),  32'h0);
        check({tag, "_mc_err"},    32'(mc_err),    32'h0);
        check({tag, "_state"},     32'(state_dbg), 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        jump_req    = 1'b0;
        jump_addr   = 32'h0;
        hold_req    = 1'b0;
        model_reset();

        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // jump: flush lasts exactly FLUSH_CYC cycles, no stall
        flush_seen = 0;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        idle(3);
        check("jump_flush_len", 32'(flush_seen), 32'(FLUSH_CYC));

        // load-use for one cycle
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // short multi-cycle op, no timeout
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("mc_err_short", 32'(mc_err), 32'h0);

        // timeout: 64 busy cycles, error sticks after release
        for (int i = 0; i < MC_TIMEOUT; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(3);
        check("mc_err_sticky", 32'(mc_err), 32'h1);

        // hold requested during a flush is deferred
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_ack_granted", 32'(hold_ack), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // simultaneous jump, execute busy and load-use: jump wins
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
        check("simul_state_flush", 32'(state_dbg), 32'h2);
        idle(3);

        // random traffic
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10, $urandom, $urandom_range(0, 99) < 20);
        idle(4);

        // asynchronous reset in the middle of a flush
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        jump_req    = 1'b0;
        hold_req    = 1'b0;
        #2;
        check("mid_flush_flush", 32'(flush), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(2);
        check("post_reset_run", 32'(state_dbg), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
